// File: rtl/keypad_input.sv
// 4x4 matrix keypad scanner with debounce, hex-digit accumulator and a
// valid/read handoff to the CPU. Optional auto-repeat via KEYPAD_AUTOREPEAT_EN.
module keypad_input #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_CNT   = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  input  logic        rd_en,
  output logic [31:0] in_data,
  output logic        in_valid,
  output logic [31:0] acc,
  output logic [3:0]  digit_count,
  output logic        key_strobe,
  output logic [3:0]  key_code
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
    $error("keypad_input: SCAN_DIV, DEBOUNCE_CNT and REPEAT_CNT must be >= 1");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    srow;
  logic [3:0]    pat;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic          ev;
  logic [3:0]    ev_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  logic [RW-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      srow     <= '1;
    end else begin
      row_meta <= key_row;
      srow     <= row_meta;
    end
  end

  // Lowest low row wins when several rows are pressed in the frozen column.
  always_comb begin
    row_idx = 2'd3;
    if (!pat[2]) row_idx = 2'd2;
    if (!pat[1]) row_idx = 2'd1;
    if (!pat[0]) row_idx = 2'd0;
    col_idx = 2'd3;
    if (!key_col[2]) col_idx = 2'd2;
    if (!key_col[1]) col_idx = 2'd1;
    if (!key_col[0]) col_idx = 2'd0;
    ev      = (state == DEBOUNCE) && (srow == pat) && (deb_cnt == DW'(DEBOUNCE_CNT - 1));
    ev_code = {row_idx, col_idx};
`ifdef KEYPAD_AUTOREPEAT_EN
    if (state == HOLD && srow != 4'hF && rep_cnt == RW'(REPEAT_CNT - 1) && key_code < 4'hE) begin
      ev      = 1'b1;
      ev_code = key_code;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      key_col     <= 4'b1110;
      pat         <= '1;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      in_data     <= '0;
      in_valid    <= 1'b0;
      acc         <= '0;
      digit_count <= '0;
      key_strobe  <= 1'b0;
      key_code    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      key_strobe <= ev;
      if (rd_en && in_valid) in_valid <= 1'b0;

      if (ev) begin
        key_code <= ev_code;
        if (ev_code == 4'hF) begin
          // A read on the same cycle frees the slot, so ENT may reload it.
          if (!in_valid || rd_en) begin
            in_data     <= acc;
            in_valid    <= 1'b1;
            acc         <= '0;
            digit_count <= '0;
          end
        end else if (ev_code == 4'hE) begin
          acc         <= '0;
          digit_count <= '0;
        end else if (digit_count < 4'd8) begin
          acc         <= {acc[27:0], ev_code};
          digit_count <= digit_count + 4'd1;
        end
      end

      case (state)
        SCAN: begin
          if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (srow != 4'hF) begin
              pat     <= srow;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              key_col <= {key_col[2:0], key_col[3]};
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (srow != pat) begin
            state    <= SCAN;
            scan_cnt <= '0;
          end else if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
            state   <= HOLD;
            deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (srow == 4'hF) begin
            state   <= RELEASE;
            deb_cnt <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt == RW'(REPEAT_CNT - 1)) rep_cnt <= '0;
          else rep_cnt <= rep_cnt + 1'b1;
`endif
        end
        RELEASE: begin
          if (srow != 4'hF) begin
            state <= HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
            state    <= SCAN;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            key_col  <= {key_col[2:0], key_col[3]};
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Directed table-driven bench for keypad_input with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_keypad_input;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        rd_en;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] acc;
  logic [3:0]  digit_count;
  logic        key_strobe;
  logic [3:0]  key_code;

  keypad_input #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_CNT(64)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col), .rd_en(rd_en),
    .in_data(in_data), .in_valid(in_valid), .acc(acc), .digit_count(digit_count),
    .key_strobe(key_strobe), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  logic       armed;
  logic [1:0] arow;
  logic [3:0] acol_pat;
  logic       force_en;
  logic [3:0] force_val;
  assign key_row = force_en ? force_val :
                   (armed && key_col == acol_pat) ? ~(4'b0001 << arow) : 4'hF;

  int checks = 0;
  int failures = 0;
  int scnt = 0;
  int exp_strobes = 0;

  always @(negedge clk) if (key_strobe === 1'b1) scnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Press a key so its column is entered fresh; the event then lands exactly
  // 12 edges after the column switch (2 sync + scan tail + 8 debounce).
  task automatic press(input logic [3:0] code, input logic rd);
    int n;
    logic [3:0] cp;
    cp = ~(4'b0001 << code[1:0]);
    arow = code[3:2];
    acol_pat = cp;
    n = 0;
    while (key_col == cp && n < 200) begin @(posedge clk); #1; n++; end
    armed = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (key_col != cp && n < 200);
    if (key_col != cp) begin
      chk("scan_reach_timeout", {28'd0, key_col}, {28'd0, cp});
      armed = 1'b0;
      return;
    end
    repeat (11) @(posedge clk);
    #1;
    chk("no_early_strobe", {31'd0, key_strobe}, 32'd0);
    rd_en = rd;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("strobe_latency", {31'd0, key_strobe}, 32'd1);
    chk("key_code", {28'd0, key_code}, {28'd0, code});
    armed = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          kind;   // 0 = key press, 1 = CPU read
    logic [3:0]  code;
    logic        rd;
    logic [31:0] acc;
    logic [3:0]  dc;
    logic [31:0] data;
    logic        valid;
  } step_t;

  step_t steps[$];

  initial begin
    int n;
    logic [3:0] c;
    rst = 1'b1; rd_en = 1'b0; armed = 1'b0; arow = '0; acol_pat = '1;
    force_en = 1'b0; force_val = 4'hF;

    steps.push_back('{0, 4'h6, 1'b0, 32'h6,        4'd1, 32'h0,   1'b0});
    steps.push_back('{0, 4'hE, 1'b0, 32'h0,        4'd0, 32'h0,   1'b0});
    steps.push_back('{0, 4'h1, 1'b0, 32'h1,        4'd1, 32'h0,   1'b0});
    steps.push_back('{0, 4'h2, 1'b0, 32'h12,       4'd2, 32'h0,   1'b0});
    steps.push_back('{0, 4'h3, 1'b0, 32'h123,      4'd3, 32'h0,   1'b0});
    steps.push_back('{0, 4'hF, 1'b0, 32'h0,        4'd0, 32'h123, 1'b1});
    steps.push_back('{1, 4'h0, 1'b0, 32'h0,        4'd0, 32'h123, 1'b0});
    steps.push_back('{0, 4'h1, 1'b0, 32'h1,        4'd1, 32'h123, 1'b0});
    steps.push_back('{0, 4'h2, 1'b0, 32'h12,       4'd2, 32'h123, 1'b0});
    steps.push_back('{0, 4'h3, 1'b0, 32'h123,      4'd3, 32'h123, 1'b0});
    steps.push_back('{0, 4'h4, 1'b0, 32'h1234,     4'd4, 32'h123, 1'b0});
    steps.push_back('{0, 4'h5, 1'b0, 32'h12345,    4'd5, 32'h123, 1'b0});
    steps.push_back('{0, 4'h6, 1'b0, 32'h123456,   4'd6, 32'h123, 1'b0});
    steps.push_back('{0, 4'h7, 1'b0, 32'h1234567,  4'd7, 32'h123, 1'b0});
    steps.push_back('{0, 4'h8, 1'b0, 32'h12345678, 4'd8, 32'h123, 1'b0});
    steps.push_back('{0, 4'h9, 1'b0, 32'h12345678, 4'd8, 32'h123, 1'b0});
    steps.push_back('{0, 4'hE, 1'b0, 32'h0,        4'd0, 32'h123, 1'b0});
    steps.push_back('{0, 4'h1, 1'b0, 32'h1,        4'd1, 32'h123, 1'b0});
    steps.push_back('{0, 4'h2, 1'b0, 32'h12,       4'd2, 32'h123, 1'b0});
    steps.push_back('{0, 4'h3, 1'b0, 32'h123,      4'd3, 32'h123, 1'b0});
    steps.push_back('{0, 4'hF, 1'b0, 32'h0,        4'd0, 32'h123, 1'b1});
    steps.push_back('{0, 4'h4, 1'b0, 32'h4,        4'd1, 32'h123, 1'b1});
    steps.push_back('{0, 4'hF, 1'b1, 32'h0,        4'd0, 32'h4,   1'b1});
    steps.push_back('{0, 4'h5, 1'b0, 32'h5,        4'd1, 32'h4,   1'b1});
    steps.push_back('{0, 4'hF, 1'b0, 32'h5,        4'd1, 32'h4,   1'b1});
    steps.push_back('{1, 4'h0, 1'b0, 32'h5,        4'd1, 32'h4,   1'b0});
    steps.push_back('{0, 4'hE, 1'b0, 32'h0,        4'd0, 32'h4,   1'b0});
    steps.push_back('{0, 4'hF, 1'b0, 32'h0,        4'd0, 32'h0,   1'b1});
    steps.push_back('{0, 4'h5, 1'b0, 32'h5,        4'd1, 32'h0,   1'b1});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_col", {28'd0, key_col}, 32'h0000000E);
    chk("rst_in_data", in_data, 32'h0);
    chk("rst_in_valid", {31'd0, in_valid}, 32'd0);
    chk("rst_acc", acc, 32'h0);
    chk("rst_digit_count", {28'd0, digit_count}, 32'd0);
    chk("rst_key_strobe", {31'd0, key_strobe}, 32'd0);
    chk("rst_key_code", {28'd0, key_code}, 32'd0);
    rst = 1'b0;

    foreach (steps[i]) begin
      if (steps[i].kind == 0) begin
        press(steps[i].code, steps[i].rd);
        exp_strobes++;
      end else begin
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
      chk($sformatf("step%0d_acc", i), acc, steps[i].acc);
      chk($sformatf("step%0d_digit_count", i), {28'd0, digit_count}, {28'd0, steps[i].dc});
      chk($sformatf("step%0d_in_data", i), in_data, steps[i].data);
      chk($sformatf("step%0d_in_valid", i), {31'd0, in_valid}, {31'd0, steps[i].valid});
      chk($sformatf("step%0d_strobes", i), scnt, exp_strobes);
    end

    // Bounce: row low for 3 raw cycles right after a column switch.
    c = key_col;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (key_col == c && n < 50);
    c = key_col;
    force_val = 4'b1101;
    force_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bounce_col_held", {28'd0, key_col}, {28'd0, c});
    @(posedge clk);
    #1;
    chk("bounce_scan_resumed", {31'd0, (key_col != c)}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bounce_no_strobe", scnt, exp_strobes);
    chk("bounce_acc", acc, 32'h5);

    // Reset in the middle of DEBOUNCE for key 6, key kept held afterwards.
    acol_pat = 4'b1011;
    arow = 2'd1;
    n = 0;
    while (key_col == acol_pat && n < 200) begin @(posedge clk); #1; n++; end
    armed = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (key_col != acol_pat && n < 200);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_key_col", {28'd0, key_col}, 32'h0000000E);
    chk("midrst_acc", acc, 32'h0);
    chk("midrst_digit_count", {28'd0, digit_count}, 32'd0);
    chk("midrst_in_data", in_data, 32'h0);
    chk("midrst_in_valid", {31'd0, in_valid}, 32'd0);
    chk("midrst_key_strobe", {31'd0, key_strobe}, 32'd0);
    chk("midrst_key_code", {28'd0, key_code}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_no_strobe", scnt, exp_strobes);
    n = 0;
    while (key_strobe !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("postrst_new_event", {31'd0, key_strobe}, 32'd1);
    chk("postrst_key_code", {28'd0, key_code}, 32'd6);
    chk("postrst_acc", acc, 32'h6);
    armed = 1'b0;
    repeat (20) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
